// File: rtl/radix_shift_add_multiplier_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package radix_shift_add_multiplier_pkg;

   // Top-level control states: load operands, iterate digits, sign-fix, present result.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_OUT
   } state_t;

   // Result width: the full double-width product or only its low half.
   function automatic int out_width(input int width, input bit full_product);
      return full_product ? 2 * width : width;
   endfunction

   // Digit size must be 1..4 bits and must divide the operand width evenly.
   function automatic bit digit_params_legal(input int width, input int digit_bits);
      return (digit_bits >= 1) && (digit_bits <= 4) && (width > 0) &&
             (width % digit_bits == 0);
   endfunction

endpackage

// File: rtl/radix_shift_add_multiplier_digit_core.sv
// Unsigned magnitude multiplier core: consumes DIGIT_BITS of b_mag per cycle,
// adding a_mag*digit into the top of a right-shifting accumulator.
module radix_shift_add_multiplier_digit_core #(
   parameter int WIDTH      = 16,
   parameter int DIGIT_BITS = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_mag_i,
   input  logic [WIDTH-1:0]     b_mag_i,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   mag_o
);

   localparam int N     = WIDTH / DIGIT_BITS;
   localparam int ACC_W = 2 * WIDTH + DIGIT_BITS;
   localparam int PW    = WIDTH + DIGIT_BITS;
   localparam int CNT_W = $clog2(N + 1);

   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;

   logic [DIGIT_BITS-1:0] digit;
   logic [PW-1:0]         partial;
   logic [PW-1:0]         sum_hi;

   assign digit   = b_q[DIGIT_BITS-1:0];
   // Upper accumulator slice holds < a_mag before the add, so the sum fits PW bits.
   assign partial = {{DIGIT_BITS{1'b0}}, a_q} * {{WIDTH{1'b0}}, digit};
   assign sum_hi  = acc_q[ACC_W-1:WIDTH] + partial;
   assign done_o  = busy_q && (cnt_q == CNT_W'(N - 1));
   assign mag_o   = acc_q[2*WIDTH-1:0];

   // Next-state for one digit step: add the aligned partial product, then shift right.
   always_comb begin
      // NOTE: every _d takes its _q as a default first so no path can infer a latch.
      acc_d  = acc_q;
      a_d    = a_q;
      b_d    = b_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         acc_d  = '0;
         a_d    = a_mag_i;
         b_d    = b_mag_i;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d = {sum_hi, acc_q[WIDTH-1:0]} >> DIGIT_BITS;
         b_d   = b_q >> DIGIT_BITS;
         cnt_d = cnt_q + 1'b1;
         if (done_o) begin
            busy_d = 1'b0;
         end
      end
   end

   // Core registers; the accumulator holds the final magnitude after the last step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         acc_q  <= acc_d;
         a_q    <= a_d;
         b_q    <= b_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/radix_shift_add_multiplier.sv
// Iterative signed/unsigned multiplier with stream-style operand and result
// channels, a one-deep buffer per operand, sign correction and overflow flag.
module radix_shift_add_multiplier
   import radix_shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int DIGIT_BITS   = 2,
   parameter int FULL_PRODUCT = 0
) (
   input  logic                                              clk,
   input  logic                                              reset_n,
   input  logic                                              tvalid_slave_1,
   input  logic [WIDTH-1:0]                                  tdata_slave_1,
   input  logic                                              tuser_slave_1,
   output logic                                              tready_slave_1,
   input  logic                                              tvalid_slave_2,
   input  logic [WIDTH-1:0]                                  tdata_slave_2,
   output logic                                              tready_slave_2,
   output logic                                              tvalid_master,
   output logic [out_width(WIDTH, FULL_PRODUCT != 0)-1:0]    tdata_master,
   output logic                                              tuser_master,
   input  logic                                              tready_master
);

   localparam int OW = out_width(WIDTH, FULL_PRODUCT != 0);

   if (!digit_params_legal(WIDTH, DIGIT_BITS)) begin : g_illegal_params
      $error("DIGIT_BITS must be 1..4 and divide WIDTH");
   end

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_buf_q, a_buf_d;
   logic [WIDTH-1:0]     b_buf_q, b_buf_d;
   logic                 mode_buf_q, mode_buf_d;
   logic                 a_full_q, a_full_d;
   logic                 b_full_q, b_full_d;
   logic                 signed_q, signed_d;
   logic                 neg_q, neg_d;
   logic                 tvalid_q, tvalid_d;
   logic [OW-1:0]        tdata_q, tdata_d;
   logic                 tuser_q, tuser_d;

   logic                 a_hs, b_hs, load;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic                 core_done;
   logic [2*WIDTH-1:0]   mag, prod;
   logic [WIDTH:0]       hi_signed;
   logic [WIDTH-1:0]     hi_unsigned;
   logic                 ovf;

   assign tready_slave_1 = ~a_full_q & reset_n;
   assign tready_slave_2 = ~b_full_q & reset_n;
   assign tvalid_master  = tvalid_q;
   assign tdata_master   = tdata_q;
   assign tuser_master   = tuser_q;

   assign a_hs = tvalid_slave_1 & tready_slave_1;
   assign b_hs = tvalid_slave_2 & tready_slave_2;
   assign load = (state_q == ST_IDLE) && a_full_q && b_full_q;

   // Magnitudes: unary minus maps the most negative value onto 2^(WIDTH-1) unsigned.
   assign a_neg = mode_buf_q & a_buf_q[WIDTH-1];
   assign b_neg = mode_buf_q & b_buf_q[WIDTH-1];
   assign a_mag = a_neg ? -a_buf_q : a_buf_q;
   assign b_mag = b_neg ? -b_buf_q : b_buf_q;

   radix_shift_add_multiplier_digit_core #(
      .WIDTH      (WIDTH),
      .DIGIT_BITS (DIGIT_BITS)
   ) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (load),
      .a_mag_i (a_mag),
      .b_mag_i (b_mag),
      .done_o  (core_done),
      .mag_o   (mag)
   );

   // Sign-corrected product; overflow means the truncated result loses information.
   assign prod        = neg_q ? -mag : mag;
   assign hi_signed   = prod[2*WIDTH-1:WIDTH-1];
   assign hi_unsigned = prod[2*WIDTH-1:WIDTH];
   assign ovf = (FULL_PRODUCT != 0) ? 1'b0 :
                signed_q ? !((&hi_signed) || !(|hi_signed)) :
                           (|hi_unsigned);

   // Buffer capture, operand load, FSM sequencing and result register next-state.
   always_comb begin
      state_d    = state_q;
      a_buf_d    = a_buf_q;
      b_buf_d    = b_buf_q;
      mode_buf_d = mode_buf_q;
      a_full_d   = a_full_q;
      b_full_d   = b_full_q;
      signed_d   = signed_q;
      neg_d      = neg_q;
      tvalid_d   = tvalid_q;
      tdata_d    = tdata_q;
      tuser_d    = tuser_q;

      // A load only happens while both buffers are full, when neither channel is ready,
      // so a load and a capture on the same channel never coincide.
      if (load) begin
         a_full_d = 1'b0;
         b_full_d = 1'b0;
         signed_d = mode_buf_q;
         neg_d    = a_neg ^ b_neg;
      end
      if (a_hs) begin
         a_full_d   = 1'b1;
         a_buf_d    = tdata_slave_1;
         mode_buf_d = tuser_slave_1;
      end
      if (b_hs) begin
         b_full_d = 1'b1;
         b_buf_d  = tdata_slave_2;
      end

      case (state_q)
         ST_IDLE: if (load) state_d = ST_CALC;
         ST_CALC: if (core_done) state_d = ST_FIX;
         ST_FIX: begin
            tdata_d  = prod[OW-1:0];
            tuser_d  = ovf;
            tvalid_d = 1'b1;
            state_d  = ST_OUT;
         end
         ST_OUT: begin
            if (tready_master) begin
               tvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All top-level registers; reset discards buffered operands and any in-flight work.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         a_buf_q    <= '0;
         b_buf_q    <= '0;
         mode_buf_q <= 1'b0;
         a_full_q   <= 1'b0;
         b_full_q   <= 1'b0;
         signed_q   <= 1'b0;
         neg_q      <= 1'b0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
         tuser_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_buf_q    <= a_buf_d;
         b_buf_q    <= b_buf_d;
         mode_buf_q <= mode_buf_d;
         a_full_q   <= a_full_d;
         b_full_q   <= b_full_d;
         signed_q   <= signed_d;
         neg_q      <= neg_d;
         tvalid_q   <= tvalid_d;
         tdata_q    <= tdata_d;
         tuser_q    <= tuser_d;
      end
   end

endmodule
